// File: rtl/fmul_normround.sv
// Normalize-and-round back end for a floating-point multiplier: 2-stage valid/ready pipeline.
// Optional status flag outputs are enabled by defining FMUL_NORMROUND_FLAGS_EN.
module fmul_normround #(
    parameter int WIDTH = 24,
    parameter int EXP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*WIDTH-1:0]      in_prod,
    input  logic signed [EXP_W+1:0] in_exp,
    input  logic                    in_sign,
    input  logic                    in_zero,
    input  logic                    in_inf,
    input  logic                    in_nan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+WIDTH-1:0]  out_data
`ifdef FMUL_NORMROUND_FLAGS_EN
    ,
    output logic                    out_overflow,
    output logic                    out_underflow,
    output logic                    out_inexact,
    output logic                    out_invalid
`endif
);
    localparam int EW = EXP_W + 2;
    localparam int DW = EXP_W + WIDTH;
    localparam logic signed [EW-1:0] EMAX  = $signed({2'b00, {EXP_W{1'b1}}});
    localparam logic signed [EW-1:0] EZERO = '0;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_ready, s1_load, s2_load;

    logic                 top;
    logic [WIDTH-1:0]     m_d;
    logic                 g_d, s_d;
    logic signed [EW-1:0] e_d;

    logic                 s1_sign_q, s1_g_q, s1_s_q;
    logic                 s1_nan_q, s1_inf_q, s1_zero_q;
    logic [WIDTH-1:0]     s1_m_q;
    logic signed [EW-1:0] s1_e_q;

    logic                 inc, carry, ovf_c, unf_c;
    logic [WIDTH:0]       m_rnd;
    logic [WIDTH-2:0]     frac;
    logic signed [EW-1:0] e_rnd;
    logic [DW-1:0]        data_d, data_q;

    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && s2_ready;

    assign s1_valid_d = in_ready ? in_valid : s1_valid_q;
    assign s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage 1: align the leading one to the top of m, split off guard and sticky.
    assign top = in_prod[2*WIDTH-1];
    assign m_d = top ? in_prod[2*WIDTH-1:WIDTH] : in_prod[2*WIDTH-2:WIDTH-1];
    assign g_d = top ? in_prod[WIDTH-1] : in_prod[WIDTH-2];
    assign s_d = top ? (|in_prod[WIDTH-2:0]) : (|in_prod[WIDTH-3:0]);
    assign e_d = in_exp + $signed({{(EW-1){1'b0}}, top});

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_sign_q <= in_sign;
            s1_m_q    <= m_d;
            s1_g_q    <= g_d;
            s1_s_q    <= s_d;
            s1_e_q    <= e_d;
            s1_nan_q  <= in_nan | (in_inf & in_zero);
            s1_inf_q  <= in_inf;
            s1_zero_q <= in_zero;
        end
    end

    // Stage 2: round to nearest even, renormalize on carry-out, then range-check and pack.
    assign inc   = s1_g_q & (s1_s_q | s1_m_q[0]);
    assign m_rnd = {1'b0, s1_m_q} + {{WIDTH{1'b0}}, inc};
    assign carry = m_rnd[WIDTH];
    assign frac  = carry ? m_rnd[WIDTH-1:1] : m_rnd[WIDTH-2:0];
    assign e_rnd = s1_e_q + $signed({{(EW-1){1'b0}}, carry});
    assign ovf_c = e_rnd >= EMAX;
    assign unf_c = e_rnd <= EZERO;

    always_comb begin
        data_d = {s1_sign_q, e_rnd[EXP_W-1:0], frac};
        if (s1_nan_q)
            data_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(WIDTH-2){1'b0}}};
        else if (s1_inf_q || (!s1_zero_q && ovf_c))
            data_d = {s1_sign_q, {EXP_W{1'b1}}, {(WIDTH-1){1'b0}}};
        else if (s1_zero_q || unf_c)
            data_d = {s1_sign_q, {(DW-1){1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_q <= '0;
        else if (s2_load)
            data_q <= data_d;
    end

    assign out_valid = s2_valid_q;
    assign out_data  = data_q;

`ifdef FMUL_NORMROUND_FLAGS_EN
    logic       finite;
    logic [3:0] flags_d, flags_q;

    assign finite  = !(s1_nan_q || s1_inf_q || s1_zero_q);
    assign flags_d = {s1_nan_q,
                      finite & (s1_g_q | s1_s_q | ovf_c | unf_c),
                      finite & !ovf_c & unf_c,
                      finite & ovf_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_q <= '0;
        else if (s2_load)
            flags_q <= flags_d;
    end

    assign {out_invalid, out_inexact, out_underflow, out_overflow} = flags_q;
`endif
endmodule

// File: tb/tb_fmul_normround.sv
// Bench for fmul_normround: directed vectors, backpressure, reset flush, random stream
// against an arithmetic reference model.
module tb_fmul_normround;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [47:0]        in_prod = '0;
    logic signed [9:0]  in_exp = '0;
    logic               in_sign = 1'b0, in_zero = 1'b0, in_inf = 1'b0, in_nan = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_data;
`ifdef FMUL_NORMROUND_FLAGS_EN
    logic out_overflow, out_underflow, out_inexact, out_invalid;
`endif

    fmul_normround #(.WIDTH(24), .EXP_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_exp(in_exp), .in_sign(in_sign), .in_zero(in_zero),
        .in_inf(in_inf), .in_nan(in_nan), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
`ifdef FMUL_NORMROUND_FLAGS_EN
        , .out_overflow(out_overflow), .out_underflow(out_underflow),
        .out_inexact(out_inexact), .out_invalid(out_invalid)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_q[$];
    logic [35:0] item;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic        acc_flag;
    int          n_pop = 0;
    logic [47:0] cur_prod;
    logic signed [9:0] cur_exp;
    logic        cur_sign, cur_zero, cur_inf, cur_nan;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: exact remainder comparison against half an ulp, then range classification.
    function automatic logic [35:0] model(input logic [47:0] p, input int ex, input logic sg,
                                          input logic z, input logic inf, input logic nan);
        longint unsigned pv, m, rem, half;
        int sh, e;
        logic ovf, unf, inx, inv;
        logic [31:0] d;
        ovf = 0; unf = 0; inx = 0; inv = 0;
        if (nan || (inf && z)) begin
            d = 32'h7FC00000; inv = 1;
        end else if (inf) begin
            d = {sg, 8'hFF, 23'h0};
        end else if (z) begin
            d = {sg, 31'h0};
        end else begin
            pv   = longint'(p);
            sh   = p[47] ? 24 : 23;
            e    = ex + (p[47] ? 1 : 0);
            m    = pv >> sh;
            rem  = pv - (m << sh);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && m[0])) m = m + 1;
            if (m == (64'd1 << 24)) begin
                m = m >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                d = {sg, 8'hFF, 23'h0}; ovf = 1; inx = 1;
            end else if (e <= 0) begin
                d = {sg, 31'h0}; unf = 1; inx = 1;
            end else begin
                d = {sg, e[7:0], m[22:0]};
            end
        end
        return {inv, inx, unf, ovf, d};
    endfunction

    task automatic new_beat();
        cur_prod = {$urandom(), $urandom()};
        if ($urandom_range(0, 1) == 1) cur_prod[47] = 1'b1;
        else cur_prod[47:46] = 2'b01;
        cur_exp  = 10'($signed($urandom_range(0, 280)) - 10);
        cur_sign = 1'($urandom());
        cur_zero = ($urandom_range(0, 15) == 0);
        cur_inf  = ($urandom_range(0, 15) == 0);
        cur_nan  = ($urandom_range(0, 31) == 0);
    endtask

    task automatic set_beat(input logic [47:0] p, input int ex, input logic sg,
                            input logic z, input logic inf, input logic nan);
        cur_prod = p; cur_exp = 10'(ex); cur_sign = sg;
        cur_zero = z; cur_inf = inf; cur_nan = nan;
    endtask

    // One cycle: drive at the falling edge, then observe the handshake that the next rising edge commits.
    task automatic step(input logic v, input logic r);
        @(negedge clk);
        in_valid = v; out_ready = r;
        in_prod = cur_prod; in_exp = cur_exp; in_sign = cur_sign;
        in_zero = cur_zero; in_inf = cur_inf; in_nan = cur_nan;
        #1;
        if (hold_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
        end
        acc_flag = in_valid && in_ready;
        if (acc_flag)
            exp_q.push_back(model(cur_prod, int'(cur_exp), cur_sign, cur_zero, cur_inf, cur_nan));
        if (out_valid && out_ready) begin
            check("result_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                item = exp_q.pop_front();
                n_pop++;
                check("data", out_data, item[31:0]);
`ifdef FMUL_NORMROUND_FLAGS_EN
                check("flags", {out_invalid, out_inexact, out_underflow, out_overflow}, item[35:32]);
`endif
            end
        end
        hold_prev = out_valid && !out_ready;
        prev_data = out_data;
    endtask

    task automatic directed(input string tag, input logic [47:0] p, input int ex, input logic sg,
                            input logic z, input logic inf, input logic nan,
                            input logic [31:0] want, input logic [3:0] want_flags);
        set_beat(p, ex, sg, z, inf, nan);
        step(1, 1);
        check({tag, "_accept"}, acc_flag, 1);
        step(0, 1);
        check({tag, "_lat1"}, out_valid, 0);
        step(0, 1);
        check({tag, "_lat2"}, out_valid, 1);
        check(tag, out_data, want);
`ifdef FMUL_NORMROUND_FLAGS_EN
        check({tag, "_flags"}, {out_invalid, out_inexact, out_underflow, out_overflow}, want_flags);
`else
        if (want_flags != 4'hF) begin end
`endif
    endtask

    initial begin
        int acc, ir_low, pops0;
        set_beat(48'h0, 0, 0, 0, 0, 0);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // flags nibble: {invalid, inexact, underflow, overflow}
        directed("one",      48'h400000000000, 127, 0, 0, 0, 0, 32'h3F800000, 4'b0000);
        directed("1p5sq",    48'h900000000000, 127, 0, 0, 0, 0, 32'h40100000, 4'b0000);
        directed("tie_odd",  48'h400000C00000, 127, 0, 0, 0, 0, 32'h3F800002, 4'b0100);
        directed("tie_even", 48'h400000400000, 127, 0, 0, 0, 0, 32'h3F800000, 4'b0100);
        directed("carry",    48'h7FFFFFC00000, 127, 0, 0, 0, 0, 32'h40000000, 4'b0100);
        directed("overflow", 48'h800000000000, 254, 0, 0, 0, 0, 32'h7F800000, 4'b0101);
        directed("underflw", 48'h800000000000, -5,  0, 0, 0, 0, 32'h00000000, 4'b0110);
        directed("inf_zero", 48'h123456789ABC, 127, 1, 1, 1, 0, 32'h7FC00000, 4'b1000);
        directed("neg_inf",  48'h400000000000, 10,  1, 0, 1, 0, 32'hFF800000, 4'b0000);
        directed("neg_zero", 48'h400000000000, 127, 1, 1, 0, 0, 32'h80000000, 4'b0000);
        directed("nan",      48'h400000000000, 127, 1, 0, 0, 1, 32'h7FC00000, 4'b1000);
        directed("exp_one",  48'h400000000000, 1,   1, 0, 0, 0, 32'h80800000, 4'b0000);

        // Four back-to-back beats with the consumer stalled for three cycles after the first result.
        acc = 0; ir_low = 0; pops0 = n_pop;
        new_beat();
        for (int c = 0; c < 30; c++) begin
            step(acc < 4, !(c >= 2 && c <= 4));
            if (in_valid && !in_ready) ir_low++;
            if (acc_flag) begin
                acc++;
                new_beat();
            end
        end
        check("bp_in_ready_fell", ir_low > 0, 1);
        check("bp_accepted", acc, 4);
        check("bp_emitted", n_pop - pops0, 4);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset with two beats in flight.
        new_beat(); step(1, 1);
        new_beat(); step(1, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("flush_inflight", out_valid, 1);
        rst = 1'b1;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_out_data", out_data, 0);
        exp_q.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(0, 1);
            check("no_stale", out_valid, 0);
        end

        // Random traffic with random backpressure.
        new_beat();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            if (acc_flag) new_beat();
        end
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) step(0, 1);
        check("drain_empty", exp_q.size(), 0);
        step(0, 1);
        check("idle_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmul_normround.md
FMUL_NORMROUND -- requirements
Module: fmul_normround

Interface
REQ-001 SHALL have parameter WIDTH, default 24: significand width including hidden bit; product input is 2*WIDTH bits.
REQ-002 SHALL have parameter EXP_W, default 8: biased result exponent width; bias = 2^(EXP_W-1)-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-007 SHALL have port in_prod, input, 2*WIDTH bits: unsigned significand product from the fixed-point multiplier.
REQ-008 SHALL have port in_exp, input, EXP_W+2 bits: two's-complement exponent sum ea+eb-bias.
REQ-009 SHALL have port in_sign, input, 1 bit: result sign (sa XOR sb).
REQ-010 SHALL have ports in_zero, in_inf, in_nan, input, 1 bit each: operand class flags (any operand zero / infinite / NaN).
REQ-011 SHALL have port out_valid, input-to-consumer, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-013 SHALL have port out_data, output, 1+EXP_W+WIDTH-1 bits: packed {sign, exponent, fraction}.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 normalize + guard/sticky extraction, S2 round/pack; latency exactly 2 cycles from accepted beat to out_valid with out_ready held high.
REQ-015 Handshake: beat transfers when valid && ready on a clock edge; S2 ready = !s2_valid || out_ready; in_ready = !s1_valid || S2 ready; one beat per cycle sustained.
REQ-016 out_data and out_valid SHALL hold stable while out_valid && !out_ready; no beat dropped or duplicated.
REQ-017 Normalize: if in_prod[2W-1]=1, m = in_prod[2W-1:W], g = in_prod[W-1], s = OR(in_prod[W-2:0]), e = in_exp+1; else m = in_prod[2W-2:W-1], g = in_prod[W-2], s = OR(in_prod[W-3:0]), e = in_exp.
REQ-018 Round to nearest even: increment m when g && (s || m[0]).
REQ-019 If rounding carries m to 2^W, m SHALL shift right 1 and e increment 1.
REQ-020 Overflow: e >= 2^EXP_W-1 -> signed infinity (exp all ones, fraction 0).
REQ-021 Underflow: e <= 0 -> signed zero (flush, no subnormals).
REQ-022 Specials, priority order: in_nan or (in_inf && in_zero) -> quiet NaN (sign 0, exp all ones, fraction MSB 1, rest 0); in_inf -> signed infinity; in_zero -> signed zero; in_prod ignored in these cases.
REQ-023 Exponent arithmetic SHALL use EXP_W+2 signed bits internally; no wrap-around.

Reset
REQ-024 On rst high: s1_valid, s2_valid, out_valid = 0; out_data = 0; flag outputs = 0; in_ready = 1 one cycle after rst deasserts (combinationally 1 while pipeline empty).
REQ-025 Reset mid-operation SHALL discard all in-flight beats; no output after deassertion until a new beat is accepted.

Configuration
REQ-026 Macro FMUL_NORMROUND_FLAGS_EN defined: SHALL add outputs out_overflow, out_underflow, out_inexact, out_invalid (1 bit each), registered with out_data, and held stable under the same backpressure as out_data; inexact = g || s for finite non-special results, and set on overflow/underflow; invalid = NaN result from inf*zero or NaN input.
REQ-027 Macro undefined: those four ports and their logic SHALL be absent; out_data behaviour unchanged.

Verification
REQ-028 in_prod=0x400000000000, in_exp=127, sign 0, out_ready=1 -> out_data=0x3F800000 exactly 2 cycles later.
REQ-029 in_prod=0x900000000000 (1.5*1.5), in_exp=127 -> 0x40100000; in_prod=0x400000C00000 -> 0x3F800002 (tie rounds to even, inexact=1); in_prod=0x400000400000 -> 0x3F800000 (inexact=1).
REQ-030 in_prod=0x7FFFFFC00000, in_exp=127 -> 0x40000000 (rounding carry renormalizes).
REQ-031 in_prod=0x800000000000, in_exp=254 -> 0x7F800000, overflow=1; in_exp=-5 -> 0x00000000, underflow=1; in_inf=1, in_zero=1 -> 0x7FC00000, invalid=1.
REQ-032 Stream 4 back-to-back beats, out_ready low for 3 cycles after first result -> in_ready falls once both stages are full, out_data held, all 4 results emitted in order with no loss.
REQ-033 Assert rst with 2 beats in flight -> out_valid=0, out_data=0 immediately; no stale result after release.
